// File: rtl/mod10_counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the modulo counter slice.
//   mod_width  : register width needed to hold 0..m-1 (never less than 1)
//   cnt_dir_e  : encoding of the up_dn control input
// ---------------------------------------------------------------------------
package counter_pkg;

    typedef enum logic {
        CNT_DOWN = 1'b0,
        CNT_UP   = 1'b1
    } cnt_dir_e;

    function automatic int mod_width(input int m);
        int w;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mod10_counter_next_state.sv
// ---------------------------------------------------------------------------
// mod_next_state
// Purely combinational neighbour calculation for a modulo-MODULUS counter.
// Ports:
//   q        in   WIDTH  current count (assumed < MODULUS)
//   up_dn    in   1      direction, 1 = up, 0 = down
//   next_up  out  WIDTH  q+1 with wrap MODULUS-1 -> 0
//   next_dn  out  WIDTH  q-1 with wrap 0 -> MODULUS-1
//   tc_raw   out  1      q sits on the wrap point for the current direction
// ---------------------------------------------------------------------------
module mod_next_state
    import counter_pkg::*;
#(
    parameter int MODULUS = 10,
    parameter int WIDTH   = mod_width(MODULUS)
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up_dn,
    output logic [WIDTH-1:0] next_up,
    output logic [WIDTH-1:0] next_dn,
    output logic             tc_raw
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    cnt_dir_e dir;
    logic     at_max;
    logic     at_zero;

    assign dir     = cnt_dir_e'(up_dn);
    assign at_max  = (q == MAX_VAL);
    assign at_zero = (q == '0);

    assign next_up = at_max  ? '0      : q + WIDTH'(1);
    assign next_dn = at_zero ? MAX_VAL : q - WIDTH'(1);

    assign tc_raw  = (dir == CNT_UP) ? at_max : at_zero;

endmodule

// File: rtl/mod10_counter.sv
// ---------------------------------------------------------------------------
// mod10_counter
// Modulo-MODULUS up/down counter (decade counter by default) with enable,
// synchronous clear, parallel load and a combinational terminal count.
// Priority on each rising edge: clear > load > en.
// Ports:
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous active-low reset
//   en        in   1      count enable            (default 1)
//   up_dn     in   1      1 = up, 0 = down        (default 1)
//   clear     in   1      synchronous clear to 0  (default 0)
//   load      in   1      synchronous load        (default 0)
//   load_val  in   WIDTH  value to load           (default 0)
//   q         out  WIDTH  registered count, always < MODULUS
//   tc        out  1      next enabled edge wraps
// ---------------------------------------------------------------------------
module mod10_counter
    import counter_pkg::*;
#(
    parameter int MODULUS = 10,
    parameter int WIDTH   = mod_width(MODULUS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en       = 1'b1,
    input  logic             up_dn    = 1'b1,
    input  logic             clear    = 1'b0,
    input  logic             load     = 1'b0,
    input  logic [WIDTH-1:0] load_val = '0,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] next_up;
    logic [WIDTH-1:0] next_dn;
    logic [WIDTH-1:0] load_fix;
    logic             tc_raw;
    cnt_dir_e         dir;

    mod_next_state #(
        .MODULUS (MODULUS),
        .WIDTH   (WIDTH)
    ) u_next (
        .q       (q_r),
        .up_dn   (up_dn),
        .next_up (next_up),
        .next_dn (next_dn),
        .tc_raw  (tc_raw)
    );

    assign dir = cnt_dir_e'(up_dn);

    // Out-of-range loads collapse to 0 so q can never leave 0..MODULUS-1.
    assign load_fix = (32'(load_val) < MODULUS) ? load_val : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_r <= '0;
        end else if (clear) begin
            q_r <= '0;
        end else if (load) begin
            q_r <= load_fix;
        end else if (en) begin
            q_r <= (dir == CNT_UP) ? next_up : next_dn;
        end
    end

    assign q = q_r;

    // Gated by reset: in down mode q=0 would otherwise flag tc during reset.
    assign tc = reset & en & ~clear & ~load & tc_raw;

endmodule

// File: tb/tb_mod10_counter.sv
module tb_mod10_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       en, up_dn, clear, load;
    logic [3:0] load_val;
    logic [3:0] q;
    logic       tc;

    logic       en6, up6, clr6, ld6;
    logic [2:0] lv6;
    logic [2:0] q6;
    logic       tc6;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mod10_counter #(.MODULUS(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up_dn    (up_dn),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .tc       (tc)
    );

    mod10_counter #(.MODULUS(6)) dut6 (
        .clk      (clk),
        .reset    (reset),
        .en       (en6),
        .up_dn    (up6),
        .clear    (clr6),
        .load     (ld6),
        .load_val (lv6),
        .q        (q6),
        .tc       (tc6)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int exp6;
        logic exp_tc6;

        reset = 1'b0; en = 1'b1; up_dn = 1'b1; clear = 1'b0; load = 1'b0; load_val = 4'd0;
        en6 = 1'b1; up6 = 1'b1; clr6 = 1'b0; ld6 = 1'b0; lv6 = 3'd0;

        // reset held low until 12 ns
        @(negedge clk);
        check("reset_q", 32'(q), 0);
        check("reset_tc", 32'(tc), 0);
        #2 reset = 1'b1;

        // free run with defaults: two wraps in 200 ns
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check("run_q", 32'(q), 32'(k % 10));
            check("run_tc", 32'(tc), ((k % 10) == 9) ? 32'd1 : 32'd0);
        end

        // advance to q = 6, then asynchronous reset between edges
        for (int k = 1; k <= 6; k++) @(negedge clk);
        check("mid_q6", 32'(q), 6);
        #2 reset = 1'b0;
        #1 check("async_rst_q", 32'(q), 0);
        up_dn = 1'b0;
        #1 check("rst_tc_gated", 32'(tc), 0);
        up_dn = 1'b1;
        @(negedge clk);
        check("rst_hold_q", 32'(q), 0);
        reset = 1'b1;
        @(negedge clk);
        check("restart_q1", 32'(q), 1);
        @(negedge clk);
        check("restart_q2", 32'(q), 2);

        // count down from 2
        up_dn = 1'b0;
        @(negedge clk);
        check("dn_q1", 32'(q), 1);
        check("dn_tc1", 32'(tc), 0);
        @(negedge clk);
        check("dn_q0", 32'(q), 0);
        check("dn_tc0", 32'(tc), 1);
        @(negedge clk);
        check("dn_q9", 32'(q), 9);
        check("dn_tc9", 32'(tc), 0);
        @(negedge clk);
        check("dn_q8", 32'(q), 8);
        up_dn = 1'b1;
        #1 check("up_tc8", 32'(tc), 0);
        @(negedge clk);
        check("up_q9", 32'(q), 9);
        check("up_tc9", 32'(tc), 1);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            check("up_q", 32'(q), 32'(k));
        end

        // hold with en = 0 at q = 4
        en = 1'b0;
        #1 check("hold_tc_now", 32'(tc), 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_q", 32'(q), 4);
            check("hold_tc", 32'(tc), 0);
        end
        en = 1'b1;
        @(negedge clk);
        check("reen_q5", 32'(q), 5);

        // loads
        load = 1'b1; load_val = 4'd7;
        @(negedge clk);
        check("load7", 32'(q), 7);
        load_val = 4'd12;
        @(negedge clk);
        check("load12_forced0", 32'(q), 0);
        clear = 1'b1; load_val = 4'd3;
        @(negedge clk);
        check("clear_beats_load", 32'(q), 0);
        clear = 1'b0; load_val = 4'd9;
        @(negedge clk);
        check("load9", 32'(q), 9);
        #1 check("load_blocks_tc", 32'(tc), 0);
        load = 1'b0;
        #1 check("tc_after_load", 32'(tc), 1);
        @(negedge clk);
        check("wrap_after_load", 32'(q), 0);
        @(negedge clk);
        check("count_q1", 32'(q), 1);
        clear = 1'b1;
        @(negedge clk);
        check("clear_q", 32'(q), 0);
        clear = 1'b0; en = 1'b0; load = 1'b1; load_val = 4'd10;
        @(negedge clk);
        check("load10_forced0", 32'(q), 0);
        load_val = 4'd3;
        @(negedge clk);
        check("load_no_en", 32'(q), 3);
        load = 1'b0; en = 1'b1;
        @(negedge clk);
        check("after_load_q4", 32'(q), 4);

        // MODULUS = 6 instance: sync to 0 with clear, then plain count
        clr6 = 1'b1;
        @(negedge clk);
        check("m6_clear", 32'(q6), 0);
        clr6 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("m6_q", 32'(q6), 32'(k % 6));
            check("m6_tc", 32'(tc6), ((k % 6) == 5) ? 32'd1 : 32'd0);
        end

        // random control mix against a reference model
        exp6 = 2;
        for (int i = 0; i < 300; i++) begin
            en6  = 1'($urandom_range(0, 1));
            up6  = 1'($urandom_range(0, 1));
            ld6  = ($urandom_range(0, 5) == 0);
            clr6 = ($urandom_range(0, 15) == 0);
            lv6  = 3'($urandom_range(0, 7));
            exp_tc6 = en6 && !clr6 && !ld6 && (up6 ? (exp6 == 5) : (exp6 == 0));
            #1 check("m6_rand_tc", 32'(tc6), 32'(exp_tc6));
            if (clr6)
                exp6 = 0;
            else if (ld6)
                exp6 = (int'(lv6) < 6) ? int'(lv6) : 0;
            else if (en6)
                exp6 = up6 ? (exp6 + 1) % 6 : (exp6 + 5) % 6;
            @(negedge clk);
            check("m6_rand_q", 32'(q6), 32'(exp6));
            check("m6_range", 32'(q6 < 3'd6), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod10_counter.md
Name: mod10_counter

Overview:
- Synchronous decade counter that cycles q through 0..9 and wraps, for use as a BCD digit, divide-by-10 prescaler or sequencing tick source.
- The modulus is parameterised with a default of 10.
- Adds enable, direction, synchronous clear, parallel load and a terminal-count output.
- Single clock domain. All extra control inputs have port defaults, so a bare clk/reset/q instantiation free-runs as an up-counter.

Parameters:
- MODULUS, 10: number of states; count range is 0..MODULUS-1. Legal range is 2..2^16.
- WIDTH, $clog2(MODULUS): width of q and load_val. It is derived and must not be overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- en  input  1  count enable; port default 1'b1.
- up_dn  input  1  1 = count up, 0 = count down; port default 1'b1.
- clear  input  1  synchronous clear to 0; port default 1'b0.
- load  input  1  synchronous parallel load; port default 1'b0.
- load_val  input  WIDTH  value to load; port default '0.
- q  output  WIDTH  current count (registered).
- tc  output  1  terminal count: the next enabled count edge will wrap (combinational).

Behaviour:
- Reset: when reset goes low, q becomes 0 immediately, without waiting for a clock. q is held at 0 while reset is low. The first change after release happens on the first rising clk edge that sees reset high.
- Per rising edge with reset high, the priority order is clear > load > en. Only one action is taken per edge.
  - clear=1: q <= 0, regardless of load and en.
  - load=1: q <= load_val if load_val < MODULUS, else q <= 0 (an out-of-range load is forced to 0). load does not require en.
  - en=1, up_dn=1: q <= (q == MODULUS-1) ? 0 : q+1.
  - en=1, up_dn=0: q <= (q == 0) ? MODULUS-1 : q-1.
  - en=0: q holds.
- tc = en & ~clear & ~load & (up_dn ? q == MODULUS-1 : q == 0).
  - tc is high for exactly the cycle preceding a wrap edge.
  - tc is forced 0 while reset is low.
- Latency: one clock from a control input to the change in q. tc reflects the current q and controls with no added latency.
- Invariant: q is never >= MODULUS on any cycle, including after a load.
- Mid-count reset: q returns asynchronously to 0. There is no saved state.
- up_dn may toggle on any cycle. The new direction applies from that edge.
- With default ports, q follows 0,1,…,9,0,… at one step per clock. tc pulses once every 10 cycles, while q = 9.

Decomposition:
- Shared package counter_pkg:
  - function mod_width(int m) returning max(1, $clog2(m));
  - typedef enum {CNT_DOWN=0, CNT_UP=1} for up_dn.
- One natural sub-module, mod_next_state (purely combinational). It takes q, up_dn and MODULUS and returns next_up/next_dn and tc_raw.
- The top level holds the register and the priority mux.

Test Plan:
- Bench clock is 10 ns. Hold reset low 12 ns, then release; run 200 ns with defaults.
  - Required: q = 0 during reset.
  - Then q steps 1,2,…,9,0,… on successive rising edges, wrapping twice within the window.
  - tc is high only while q = 9.
- Assert reset low asynchronously at mid-count (q = 6), between clock edges -> q reads 0 before the next edge. Release -> counting restarts 0,1,2.
- Set up_dn = 0 from q = 2 -> q = 1, 0, 9, 8. tc is high while q = 0.
- Set en = 0 at q = 4 for 5 cycles -> q stays 4 and tc = 0. Re-enable -> q = 5.
- Load tests:
  - load = 1, load_val = 7 -> q = 7 next edge.
  - load_val = 12 -> q = 0.
  - load = 1 with clear = 1 and load_val = 3 -> q = 0 (clear wins).
- Instantiate with MODULUS = 6 (WIDTH = 3) -> q cycles 0..5 and wraps. Check q < 6 holds on every cycle with a random en/up_dn/load mix.
